// File: rtl/scoreboard_per_warp.sv
// Per-warp register scoreboard.
// Tracks the destination registers of issued instructions that have not yet
// been written back. It tells the issue unit whether the instruction at the
// head of the buffer is free of RAW/WAW hazards. It also flags protocol
// misuse with a sticky error bit.
module scoreboard_per_warp #(
    parameter int NUM_ENTRIES    = 4,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [REG_ADDR_WIDTH-1:0]          Src1_IB_SB,
    input  logic                               Src1_valid_IB_SB,
    input  logic [REG_ADDR_WIDTH-1:0]          Src2_IB_SB,
    input  logic                               Src2_valid_IB_SB,
    input  logic [REG_ADDR_WIDTH-1:0]          Dst_IB_SB,
    input  logic                               Dst_valid_IB_SB,
    input  logic                               issue_IU_SB,
    input  logic [REG_ADDR_WIDTH-1:0]          Dst_WB_SB,
    input  logic                               valid_WB_SB,
    output logic                               hazard_free_SB_IU,
    output logic                               full_SB,
    output logic                               empty_SB,
    output logic [$clog2(NUM_ENTRIES+1)-1:0]   pending_count_SB,
    output logic                               err_SB
);

    localparam int CW = $clog2(NUM_ENTRIES + 1);

    logic [NUM_ENTRIES-1:0]    ent_valid;
    logic [REG_ADDR_WIDTH-1:0] ent_addr [NUM_ENTRIES];
    logic                      err;

    logic                      src1_hit;
    logic                      src2_hit;
    logic                      dst_hit;
    logic [NUM_ENTRIES-1:0]    wb_match;
    logic [NUM_ENTRIES-1:0]    alloc_sel;
    logic                      free_found;
    logic [CW-1:0]             count;
    logic                      do_alloc;
    logic                      protocol_err;

    // Compare the head operands and the writeback register against every
    // valid entry. Also pick the lowest free slot and count occupancy.
    // Everything here uses only the registered state, so a writeback in
    // this cycle cannot unblock the head until the next cycle.
    always_comb begin
        src1_hit   = 1'b0;
        src2_hit   = 1'b0;
        dst_hit    = 1'b0;
        wb_match   = '0;
        alloc_sel  = '0;
        free_found = 1'b0;
        count      = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (ent_valid[i]) begin
                count = count + CW'(1);
                if (ent_addr[i] == Src1_IB_SB) src1_hit = 1'b1;
                if (ent_addr[i] == Src2_IB_SB) src2_hit = 1'b1;
                if (ent_addr[i] == Dst_IB_SB)  dst_hit  = 1'b1;
                if (ent_addr[i] == Dst_WB_SB)  wb_match[i] = 1'b1;
            end else if (!free_found) begin
                free_found   = 1'b1;
                alloc_sel[i] = 1'b1;
            end
        end
    end

    assign full_SB           = &ent_valid;
    assign empty_SB          = ~|ent_valid;
    assign pending_count_SB  = count;
    assign err_SB            = err;

    // A destination-writing instruction also needs a free slot. An
    // instruction that writes no register is never held back by a full board.
    assign hazard_free_SB_IU = !(Src1_valid_IB_SB && src1_hit)
                            && !(Src2_valid_IB_SB && src2_hit)
                            && !(Dst_valid_IB_SB && (dst_hit || full_SB));

    assign do_alloc     = issue_IU_SB && hazard_free_SB_IU && Dst_valid_IB_SB;
    assign protocol_err = (issue_IU_SB && !hazard_free_SB_IU)
                       || (valid_WB_SB && !(|wb_match));

    // Valid bits and sticky error flag.
    // The allocated slot was free before the edge and the released slot was
    // valid, so the two can never collide on the same entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            ent_valid <= '0;
            err       <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (do_alloc && alloc_sel[i]) begin
                    ent_valid[i] <= 1'b1;
                end else if (valid_WB_SB && wb_match[i]) begin
                    ent_valid[i] <= 1'b0;
                end
            end
            if (protocol_err) begin
                err <= 1'b1;
            end
        end
    end

    // Register addresses are only meaningful while their valid bit is set,
    // so they need no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (do_alloc && alloc_sel[i]) begin
                ent_addr[i] <= Dst_IB_SB;
            end
        end
    end

endmodule

// File: tb/tb_scoreboard_per_warp.sv
// Testbench for scoreboard_per_warp.
// It runs a directed vector table, then hand-written reset sequences, then
// randomized traffic. The random traffic is compared against a set-based
// model of the outstanding registers.
module tb_scoreboard_per_warp;

    localparam int N  = 4;
    localparam int AW = 5;
    localparam int CW = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] src1, src2, dst, wb_dst;
    logic          s1v, s2v, dv, issue, wbv;
    logic          hf, full, empty, err;
    logic [CW-1:0] cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    scoreboard_per_warp #(.NUM_ENTRIES(N), .REG_ADDR_WIDTH(AW)) dut (
        .clk               (clk),
        .rst               (rst),
        .Src1_IB_SB        (src1),
        .Src1_valid_IB_SB  (s1v),
        .Src2_IB_SB        (src2),
        .Src2_valid_IB_SB  (s2v),
        .Dst_IB_SB         (dst),
        .Dst_valid_IB_SB   (dv),
        .issue_IU_SB       (issue),
        .Dst_WB_SB         (wb_dst),
        .valid_WB_SB       (wbv),
        .hazard_free_SB_IU (hf),
        .full_SB           (full),
        .empty_SB          (empty),
        .pending_count_SB  (cnt),
        .err_SB            (err)
    );

    typedef struct {
        int s1; bit s1v; int s2; bit s2v; int d; bit dv; bit iss;
        int wb; bit wbv;
        bit hf; int cnt; bit err;
    } vec_t;

    vec_t tbl[$];

    // reference model: set of outstanding registers plus a sticky error
    int m_pend[$];
    bit m_err;

    function automatic bit m_has(int r);
        foreach (m_pend[k]) if (m_pend[k] == r) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input int s1_, input bit s1v_, input int s2_, input bit s2v_,
                       input int d_, input bit dv_, input bit iss_, input int wb_, input bit wbv_,
                       input bit hf_, input int cnt_, input bit err_);
        vec_t v;
        v.s1 = s1_; v.s1v = s1v_; v.s2 = s2_; v.s2v = s2v_; v.d = d_; v.dv = dv_;
        v.iss = iss_; v.wb = wb_; v.wbv = wbv_; v.hf = hf_; v.cnt = cnt_; v.err = err_;
        tbl.push_back(v);
    endtask

    task automatic drive(input int s1_, input bit s1v_, input int s2_, input bit s2v_,
                         input int d_, input bit dv_, input bit iss_, input int wb_, input bit wbv_);
        src1 = AW'(s1_); s1v = s1v_; src2 = AW'(s2_); s2v = s2v_;
        dst = AW'(d_); dv = dv_; issue = iss_; wb_dst = AW'(wb_); wbv = wbv_;
    endtask

    // check the combinational grant, clock one edge, check registered status
    task automatic step_check(input string tag, input bit ehf, input int ecnt, input bit eerr);
        #1;
        check({tag, "_hf"}, 32'(hf), 32'(ehf));
        @(posedge clk);
        #1;
        check({tag, "_cnt"},   32'(cnt),   32'(ecnt));
        check({tag, "_full"},  32'(full),  32'(ecnt == N));
        check({tag, "_empty"}, 32'(empty), 32'(ecnt == 0));
        check({tag, "_err"},   32'(err),   32'(eerr));
    endtask

    task automatic pulse_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        //   s1 v  s2 v  d  v  iss wb v   hf cnt err
        add(3, 1, 0, 0, 5, 1, 1, 0, 0,   1, 1, 0);   // first issue
        add(0, 0, 5, 1, 6, 1, 0, 0, 0,   0, 1, 0);   // RAW on src2
        add(0, 0, 5, 1, 6, 1, 0, 5, 1,   0, 0, 0);   // WB 5 same cycle: still blocked
        add(0, 0, 5, 1, 6, 1, 0, 0, 0,   1, 0, 0);   // unblocked one cycle later
        add(0, 0, 0, 0, 1, 1, 1, 0, 0,   1, 1, 0);
        add(0, 0, 0, 0, 2, 1, 1, 0, 0,   1, 2, 0);
        add(0, 0, 0, 0, 3, 1, 1, 0, 0,   1, 3, 0);
        add(0, 0, 0, 0, 4, 1, 1, 0, 0,   1, 4, 0);   // full
        add(0, 0, 0, 0, 6, 1, 0, 0, 0,   0, 4, 0);   // full blocks dst writer
        add(7, 1, 8, 1, 0, 0, 1, 0, 0,   1, 4, 0);   // no-dst instr passes full
        add(7, 1, 8, 1, 0, 0, 1, 2, 1,   1, 3, 0);   // release + no-dst issue
        add(0, 0, 0, 0, 9, 1, 1, 3, 1,   1, 3, 0);   // release + allocate
        add(9, 1, 0, 0, 10, 1, 0, 0, 0,  0, 3, 0);   // 9 tracked
        add(1, 1, 0, 0, 10, 1, 0, 0, 0,  0, 3, 0);   // 1 tracked
        add(0, 0, 4, 1, 10, 1, 0, 0, 0,  0, 3, 0);   // 4 tracked
        add(3, 1, 2, 1, 10, 1, 0, 0, 0,  1, 3, 0);   // 2,3 released
        add(0, 0, 0, 0, 0, 0, 0, 12, 1,  1, 3, 1);   // stray writeback
        add(9, 1, 0, 0, 11, 1, 1, 0, 0,  0, 3, 1);   // issue while blocked
        add(0, 0, 0, 0, 11, 1, 0, 0, 0,  1, 3, 1);   // 11 was not allocated

        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_cnt",   32'(cnt),   32'd0);
        check("reset_empty", 32'(empty), 32'd1);
        check("reset_full",  32'(full),  32'd0);
        check("reset_err",   32'(err),   32'd0);

        foreach (tbl[i]) begin
            drive(tbl[i].s1, tbl[i].s1v, tbl[i].s2, tbl[i].s2v, tbl[i].d, tbl[i].dv,
                  tbl[i].iss, tbl[i].wb, tbl[i].wbv);
            step_check($sformatf("row%0d", i), tbl[i].hf, tbl[i].cnt, tbl[i].err);
        end

        // reset with {1,4,9} outstanding and err set
        pulse_reset();
        check("midrst_empty", 32'(empty), 32'd1);
        check("midrst_cnt",   32'(cnt),   32'd0);
        check("midrst_err",   32'(err),   32'd0);
        drive(9, 1, 4, 1, 10, 1, 0, 0, 0);
        step_check("midrst_src", 1'b1, 0, 1'b0);
        drive(0, 0, 0, 0, 0, 0, 0, 4, 1);
        step_check("midrst_latewb", 1'b1, 0, 1'b1);
        pulse_reset();
        check("rst_clr_err", 32'(err), 32'd0);

        // randomized traffic against the set model
        m_pend.delete();
        m_err = 1'b0;
        for (int c = 0; c < 400; c++) begin
            int r_s1, r_s2, r_d, r_wb, idx;
            bit r_s1v, r_s2v, r_dv, r_iss, r_wbv, r_rst, ehf;
            r_rst = ($urandom_range(0, 39) == 0);
            r_s1  = $urandom_range(0, 7);  r_s1v = $urandom_range(0, 1);
            r_s2  = $urandom_range(0, 7);  r_s2v = $urandom_range(0, 1);
            r_d   = $urandom_range(0, 7);  r_dv  = ($urandom_range(0, 3) != 0);
            r_wbv = $urandom_range(0, 1);
            if (m_pend.size() > 0 && $urandom_range(0, 4) != 0)
                r_wb = m_pend[$urandom_range(0, m_pend.size() - 1)];
            else
                r_wb = $urandom_range(0, 15);
            ehf = !(r_s1v && m_has(r_s1)) && !(r_s2v && m_has(r_s2))
               && !(r_dv && (m_has(r_d) || m_pend.size() == N));
            r_iss = ehf ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) == 0);
            drive(r_s1, r_s1v, r_s2, r_s2v, r_d, r_dv, r_iss, r_wb, r_wbv);
            rst = r_rst;
            if (r_rst) begin
                m_pend.delete();
                m_err = 1'b0;
            end else begin
                if (r_wbv) begin
                    idx = -1;
                    foreach (m_pend[k]) if (m_pend[k] == r_wb) idx = k;
                    if (idx >= 0) m_pend.delete(idx);
                    else m_err = 1'b1;
                end
                if (r_iss) begin
                    if (!ehf) m_err = 1'b1;
                    else if (r_dv) m_pend.push_back(r_d);
                end
            end
            step_check($sformatf("rnd%0d", c), ehf, m_pend.size(), m_err);
            rst = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
